// File: rtl/mult4_pkg.sv
// Shared definitions for the 4x4 shift-and-add multiplier: widths, step count,
// FSM state encoding and the debug view of the internal state.
package mult4_pkg;

  localparam int MULT_WIDTH  = 4;
  localparam int MULT_STEPS  = 4;
  localparam int MULT_PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Debug snapshot of the FSM and datapath registers.
  typedef struct packed {
    mult_state_e state;
    logic [2:0]  cnt;
    logic [8:0]  p;
  } mult_dbg_t;

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple-carry adder: a chain of full adders from bit 0 to bit 3.
module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic carry;

  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/shift_add_multiplier_4bit.sv
// Sequential 4x4 unsigned shift-and-add multiplier, one partial product per
// clock through the ripple-carry adder. Optional MULT_ZERO_BYPASS_EN: zero operand finishes in one cycle.
module shift_add_multiplier_4bit
  import mult4_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output mult_dbg_t            dbg
);

  // Handshake: start is sampled on a rising edge in IDLE or DONE (ignored in
  // RUN); busy is high for the whole RUN phase; done pulses for one cycle and
  // product is valid from that cycle until the next accepted start or reset.

  localparam logic [2:0] LAST_STEP = 3'(MULT_STEPS - 1);

  mult_state_e        state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH:0]   p_q;
  logic [2:0]         cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH:0]   p_d;

  assign add_b = p_q[0] ? mcand_q : '0;

  ripple_carry_adder_4bit u_adder (
    .a    (p_q[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // {cout, sum, lo} shifted right by one; the vacated top bit is zero.
  assign p_d = {1'b0, add_cout, add_sum, p_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_q <= a;
            p_q     <= {1'b0, {WIDTH{1'b0}}, b};
            cnt_q   <= '0;
`ifdef MULT_ZERO_BYPASS_EN
            if (a == '0 || b == '0) begin
              state_q   <= DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              product_q <= '0;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
`else
            state_q <= RUN;
            busy_q  <= 1'b1;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == LAST_STEP) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= p_d[2*WIDTH-1:0];
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign dbg     = '{state: state_q, cnt: cnt_q, p: p_q};

endmodule

// File: tb/tb_shift_add_multiplier_4bit.sv
// Self-checking bench for shift_add_multiplier_4bit: vector table, hand-written
// handshake corner cases and randomized operands against a product model.
module tb_shift_add_multiplier_4bit;
  import mult4_pkg::*;

`ifdef MULT_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp_p;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] product;
  mult_dbg_t  dbg;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[12];

  shift_add_multiplier_4bit #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .dbg     (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // busy and done are never high together
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (busy === 1'b1 && done === 1'b1) begin
        errors++;
        $display("FAIL busy_done_overlap: got busy=1 done=1, required not both");
      end
    end
  end

  task automatic wait_done(input int max_cycles, output int n);
    n = 0;
    while (done !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_result(input string name);
    logic [7:0] exp;
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " product"}, 32'(product), 32'(exp));
    check({name, " busy_at_done"}, 32'(busy), 32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic [7:0] exp_p, input string name);
    int n;
    bit byp;
    byp = BYPASS && (ta == 4'd0 || tb_v == 4'd0);
    @(negedge clk);
    a = ta;
    b = tb_v;
    start = 1'b1;
    exp_q.push_back(exp_p);
    @(negedge clk);
    start = 1'b0;
    check({name, " busy_after_accept"}, 32'(busy), byp ? 32'd0 : 32'd1);
    wait_done(16, n);
    check({name, " latency"}, 32'(n), byp ? 32'd0 : 32'd4);
    check_result(name);
    @(negedge clk);
    check({name, " done_pulse_width"}, 32'(done), 32'd0);
    check({name, " product_held"}, 32'(product), 32'(exp_p));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int done_cnt;
    int pa, pb;

    vecs[0]  = '{4'd3,  4'd5,  8'h0F};
    vecs[1]  = '{4'd15, 4'd15, 8'hE1};
    vecs[2]  = '{4'd0,  4'd9,  8'h00};
    vecs[3]  = '{4'd10, 4'd12, 8'h78};
    vecs[4]  = '{4'd7,  4'd8,  8'h38};
    vecs[5]  = '{4'd9,  4'd9,  8'h51};
    vecs[6]  = '{4'd6,  4'd7,  8'h2A};
    vecs[7]  = '{4'd1,  4'd1,  8'h01};
    vecs[8]  = '{4'd15, 4'd1,  8'h0F};
    vecs[9]  = '{4'd1,  4'd15, 8'h0F};
    vecs[10] = '{4'd0,  4'd0,  8'h00};
    vecs[11] = '{4'd8,  4'd2,  8'h10};

    do_reset();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", 32'(product), 32'd0);
    check("reset state", 32'(dbg.state), 32'(IDLE));

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_p, $sformatf("vec%0d", i));

    // start during RUN is ignored: one done, operands not re-captured
    @(negedge clk);
    a = 4'd10; b = 4'd12; start = 1'b1;
    exp_q.push_back(8'h78);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 4'd0; b = 4'd0;
    wait_done(16, n);
    check("ignored_start latency", 32'(n + 2), 32'd4);
    check_result("ignored_start");
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("ignored_start extra_done", 32'(done_cnt), 32'd0);

    // back-to-back: restart in the DONE cycle
    @(negedge clk);
    a = 4'd7; b = 4'd8; start = 1'b1;
    exp_q.push_back(8'h38);
    @(negedge clk);
    start = 1'b0;
    wait_done(16, n);
    check("b2b first latency", 32'(n), 32'd4);
    check_result("b2b first");
    a = 4'd9; b = 4'd9; start = 1'b1;
    exp_q.push_back(8'h51);
    @(negedge clk);
    start = 1'b0;
    check("b2b second busy", 32'(busy), 32'd1);
    check("b2b second done_low", 32'(done), 32'd0);
    wait_done(16, n);
    check("b2b done spacing", 32'(n + 1), 32'd5);
    check_result("b2b second");

    // start held high re-triggers at every DONE
    @(negedge clk);
    a = 4'd2; b = 4'd3; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(8'h06);
      @(negedge clk);
      wait_done(16, n);
      check($sformatf("held_start%0d latency", k), 32'(n), 32'd4);
      check_result($sformatf("held_start%0d", k));
    end
    start = 1'b0;
    @(negedge clk);
    check("held_start release done", 32'(done), 32'd0);

    // reset mid-run aborts immediately
    @(negedge clk);
    a = 4'd6; b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst product", 32'(product), 32'd0);
    check("midrst state", 32'(dbg.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    run_op(4'd6, 4'd7, 8'h2A, "after_midrst");

    // randomized operands against the arithmetic product
    for (int i = 0; i < 40; i++) begin
      pa = int'($urandom_range(0, 15));
      pb = int'($urandom_range(0, 15));
      run_op(4'(pa), 4'(pb), 8'(pa * pb), $sformatf("rand%0d", i));
    end

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
